// File: rtl/manager_flash_burst.sv
// Burst flash manager: runs host read/write bursts over the fb_start/fb_done flash bus,
// returning read words through tx_trig/tx_done and pulling write words through rx_valid/rx_ready.
module manager_flash_burst #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              CLK_50MHZ,
  input  logic              RST,
  input  logic              fl_trg,
  input  logic              cmd_rx,
  input  logic [ADDR_W-1:0] addr_rx,
  input  logic [LEN_W-1:0]  len_rx,
  input  logic [DATA_W-1:0] data_rx,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              FL_FLOW,
  output logic [ADDR_W-1:0] FL_ADDR,
  inout  wire  [DATA_W-1:0] FL_DATA,
  output logic              fb_start,
  input  logic              fb_done,
  output logic [DATA_W-1:0] data_tx,
  output logic              tx_trig,
  input  logic              tx_done,
  output logic              busy,
  output logic              err_timeout
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    FB_START,
    FB_WAIT,
    TX_TRIG,
    TX_WAIT
  } state_t;

  state_t              state;
  state_t              next_state;
  logic                cmd;
  logic                nxt_cmd;
  logic [ADDR_W-1:0]   cur_addr;
  logic [ADDR_W-1:0]   nxt_addr;
  logic [LEN_W-1:0]    remain;
  logic [LEN_W-1:0]    nxt_remain;
  logic [TCNT_W-1:0]   tcnt;
  logic [DATA_W-1:0]   wbuf;
  logic                drive;
  logic                word_done;
  logic                timeout;

  assign FL_DATA = drive ? wbuf : {DATA_W{1'bz}};

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    nxt_cmd    = cmd;
    nxt_addr   = cur_addr;
    nxt_remain = remain;
    word_done  = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (fl_trg) begin
          nxt_cmd    = cmd_rx;
          nxt_addr   = addr_rx;
          nxt_remain = len_rx;
          next_state = cmd_rx ? FB_START : WDATA;
        end
      end
      WDATA: begin
        if (rx_valid) next_state = FB_START;
      end
      FB_START: next_state = FB_WAIT;
      FB_WAIT: begin
        // fb_done takes priority over a timeout landing on the same cycle
        if (fb_done) begin
          if (cmd) next_state = TX_TRIG;
          else     word_done  = 1'b1;
        end else if (tcnt == TCNT_MAX) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end
      end
      TX_TRIG: next_state = TX_WAIT;
      TX_WAIT: begin
        if (tx_done) word_done = 1'b1;
      end
      default: next_state = IDLE;
    endcase

    if (word_done) begin
      if (remain == '0) begin
        next_state = IDLE;
      end else begin
        nxt_remain = remain - LEN_W'(1);
        nxt_addr   = cur_addr + ADDR_W'(1);
        next_state = cmd ? FB_START : WDATA;
      end
    end
  end

  // Registered outputs: bus address/direction/drive follow the state being entered,
  // so they are stable for the whole FB_START/FB_WAIT window; strobes trail the state by one cycle.
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      cmd         <= 1'b0;
      cur_addr    <= '0;
      remain      <= '0;
      tcnt        <= '0;
      rx_ready    <= 1'b0;
      FL_FLOW     <= 1'b0;
      FL_ADDR     <= '0;
      drive       <= 1'b0;
      fb_start    <= 1'b0;
      data_tx     <= '0;
      tx_trig     <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      cmd      <= nxt_cmd;
      cur_addr <= nxt_addr;
      remain   <= nxt_remain;
      if (state == FB_WAIT && next_state == FB_WAIT) tcnt <= tcnt + TCNT_W'(1);
      else                                           tcnt <= '0;
      rx_ready <= (next_state == WDATA);
      busy     <= (next_state != IDLE);
      fb_start <= (state == FB_START);
      tx_trig  <= (state == TX_TRIG);
      if (next_state == FB_START) begin
        FL_ADDR <= nxt_addr;
        FL_FLOW <= nxt_cmd;
      end
      drive <= !nxt_cmd && (next_state == FB_START || next_state == FB_WAIT);
      if (state == FB_WAIT && fb_done && cmd) data_tx <= FL_DATA;
      if (state == IDLE && fl_trg) err_timeout <= 1'b0;
      else if (timeout)            err_timeout <= 1'b1;
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (state == WDATA && rx_valid) wbuf <= data_rx;
  end

endmodule

// File: tb/tb_manager_flash_burst.sv
// Bench for manager_flash_burst: table-driven bursts, hand-written latency/timeout/reset
// sequences and random bursts checked against a word-level model of the burst rules.
module tb_manager_flash_burst;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LW = 4;
  localparam int TO = 8;

  logic          CLK_50MHZ = 1'b0;
  logic          RST = 1'b1;
  logic          fl_trg = 1'b0;
  logic          cmd_rx = 1'b0;
  logic [AW-1:0] addr_rx = '0;
  logic [LW-1:0] len_rx = '0;
  logic [DW-1:0] data_rx = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          FL_FLOW;
  logic [AW-1:0] FL_ADDR;
  wire  [DW-1:0] FL_DATA;
  logic          fb_start;
  logic          fb_done = 1'b0;
  logic [DW-1:0] data_tx;
  logic          tx_trig;
  logic          tx_done = 1'b0;
  logic          busy;
  logic          err_timeout;

  logic          drv = 1'b0;
  logic [DW-1:0] drv_val = '0;
  assign FL_DATA = drv ? drv_val : {DW{1'bz}};

  manager_flash_burst #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .TIMEOUT_CYC(TO)
  ) dut (
    .CLK_50MHZ(CLK_50MHZ), .RST(RST), .fl_trg(fl_trg), .cmd_rx(cmd_rx),
    .addr_rx(addr_rx), .len_rx(len_rx), .data_rx(data_rx), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .FL_FLOW(FL_FLOW), .FL_ADDR(FL_ADDR), .FL_DATA(FL_DATA),
    .fb_start(fb_start), .fb_done(fb_done), .data_tx(data_tx), .tx_trig(tx_trig),
    .tx_done(tx_done), .busy(busy), .err_timeout(err_timeout)
  );

  always #10 CLK_50MHZ = ~CLK_50MHZ;

  int fb_cnt = 0;
  int tx_cnt = 0;
  always @(negedge CLK_50MHZ) begin
    if (fb_start) fb_cnt <= fb_cnt + 1;
    if (tx_trig)  tx_cnt <= tx_cnt + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] mem [256];
  logic [7:0] wq  [16];
  int         dly [16];
  int         last_addr;

  typedef struct {
    bit cmd;
    int addr;
    int len;
    bit stray;
    int exp_last;
    int exp_words;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_50MHZ);
    #1;
  endtask

  task automatic start_cmd(input bit cmd, input int addr, input int len);
    fl_trg  = 1'b1;
    cmd_rx  = cmd;
    addr_rx = AW'(addr);
    len_rx  = LW'(len);
    tick();
    fl_trg  = 1'b0;
  endtask

  // Model: word i of a burst goes to (addr+i) mod 256; reads return mem[], writes carry wq[].
  task automatic run_burst(input bit cmd, input int addr, input int len, input bit stray);
    int fb0, tx0, ea, n;
    fb0 = fb_cnt;
    tx0 = tx_cnt;
    start_cmd(cmd, addr, len);
    chk("busy_after_trg", int'(busy), 1);
    for (int i = 0; i <= len; i++) begin
      ea = (addr + i) % 256;
      if (!cmd) begin
        n = 0;
        while (!rx_ready && n < 50) begin tick(); n++; end
        chk("rx_ready_wait", int'(rx_ready), 1);
        for (int d = 0; d < dly[i]; d++) tick();
        chk("rx_ready_held", int'(rx_ready), 1);
        rx_valid = 1'b1;
        data_rx  = wq[i];
        tick();
        rx_valid = 1'b0;
        chk("rx_ready_drop", int'(rx_ready), 0);
      end
      n = 0;
      while (!fb_start && n < 50) begin tick(); n++; end
      chk("fb_start_wait", int'(fb_start), 1);
      chk("fl_addr", int'(FL_ADDR), ea);
      chk("fl_flow", int'(FL_FLOW), int'(cmd));
      last_addr = int'(FL_ADDR);
      if (!cmd) begin
        chk("fl_data_wr", int'(FL_DATA), int'(wq[i]));
        mem[ea] = wq[i];
      end
      for (int d = 0; d < dly[i] % 5; d++) tick();
      if (!cmd) chk("fl_data_hold", int'(FL_DATA), int'(wq[i]));
      if (cmd) begin
        drv     = 1'b1;
        drv_val = mem[ea];
      end
      fb_done = 1'b1;
      tick();
      fb_done = 1'b0;
      drv     = 1'b0;
      if (cmd) begin
        chk("data_tx_capture", int'(data_tx), int'(mem[ea]));
        n = 0;
        while (!tx_trig && n < 50) begin tick(); n++; end
        chk("tx_trig_wait", int'(tx_trig), 1);
        chk("data_tx_held", int'(data_tx), int'(mem[ea]));
        for (int d = 0; d < 1 + dly[i] % 4; d++) tick();
        chk("tx_cnt_before_done", tx_cnt - tx0, i + 1);
        chk("fb_cnt_in_tx_wait", fb_cnt - fb0, i + 1);
        if (stray) begin
          fl_trg   = 1'b1;
          cmd_rx   = ~cmd;
          addr_rx  = 8'h55;
          fb_done  = 1'b1;
          rx_valid = 1'b1;
          tick();
          fl_trg   = 1'b0;
          fb_done  = 1'b0;
          rx_valid = 1'b0;
          tick();
          chk("stray_fb_cnt", fb_cnt - fb0, i + 1);
          chk("stray_busy", int'(busy), 1);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
      end
    end
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    chk("busy_end", int'(busy), 0);
    tick();
    chk("fb_count", fb_cnt - fb0, len + 1);
    chk("tx_count", tx_cnt - tx0, cmd ? len + 1 : 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fb0, tx0, n;
    tbl[0] = '{cmd: 1'b1, addr: 'hFE, len: 3,  stray: 1'b0, exp_last: 'h01, exp_words: 4};
    tbl[1] = '{cmd: 1'b0, addr: 'h20, len: 1,  stray: 1'b0, exp_last: 'h21, exp_words: 2};
    tbl[2] = '{cmd: 1'b1, addr: 'h30, len: 2,  stray: 1'b1, exp_last: 'h32, exp_words: 3};
    tbl[3] = '{cmd: 1'b0, addr: 'hF8, len: 15, stray: 1'b0, exp_last: 'h07, exp_words: 16};
    tbl[4] = '{cmd: 1'b1, addr: 'hFF, len: 0,  stray: 1'b0, exp_last: 'hFF, exp_words: 1};
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'hA5;

    // Reset state
    tick(); tick();
    RST = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_fb_start", int'(fb_start), 0);
    chk("rst_tx_trig", int'(tx_trig), 0);
    chk("rst_rx_ready", int'(rx_ready), 0);
    chk("rst_fl_flow", int'(FL_FLOW), 0);
    chk("rst_fl_addr", int'(FL_ADDR), 0);
    chk("rst_data_tx", int'(data_tx), 0);
    chk("rst_err", int'(err_timeout), 0);

    // Single read with exact cycle latencies
    fb0 = fb_cnt;
    tx0 = tx_cnt;
    start_cmd(1'b1, 'h10, 0);
    chk("lat_fb_start_k", int'(fb_start), 0);
    chk("lat_busy_k", int'(busy), 1);
    tick();
    chk("lat_fb_start_k1", int'(fb_start), 1);
    chk("lat_fl_addr", int'(FL_ADDR), 'h10);
    chk("lat_fl_flow", int'(FL_FLOW), 1);
    tick();
    chk("lat_fb_start_k2", int'(fb_start), 0);
    tick(); tick();
    drv = 1'b1; drv_val = mem[8'h10]; fb_done = 1'b1;
    tick();
    drv = 1'b0; fb_done = 1'b0;
    chk("lat_data_tx_m", int'(data_tx), 'hA5);
    chk("lat_tx_trig_m", int'(tx_trig), 0);
    tick();
    chk("lat_tx_trig_m1", int'(tx_trig), 1);
    tick();
    chk("lat_tx_trig_m2", int'(tx_trig), 0);
    chk("lat_busy_txwait", int'(busy), 1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("lat_busy_done", int'(busy), 0);
    tick();
    chk("lat_fb_count", fb_cnt - fb0, 1);
    chk("lat_tx_count", tx_cnt - tx0, 1);

    // Table of bursts
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 16; i++) begin
        wq[i]  = 8'(17 * (i + 1));
        dly[i] = (i == 1) ? 5 : 0;
      end
      fb0 = fb_cnt;
      run_burst(tbl[t].cmd, tbl[t].addr, tbl[t].len, tbl[t].stray);
      chk("tbl_last_addr", last_addr, tbl[t].exp_last);
      chk("tbl_words", fb_cnt - fb0, tbl[t].exp_words);
      if (!tbl[t].cmd) begin
        drv = 1'b1; drv_val = 8'hC3;
        tick();
        chk("tbl_bus_released", int'(FL_DATA), 'hC3);
        drv = 1'b0;
      end
    end

    // Timeout: fb_done never arrives
    fb0 = fb_cnt;
    start_cmd(1'b1, 'h40, 2);
    n = 0;
    while (!fb_start && n < 50) begin tick(); n++; end
    chk("to_fb_start", int'(fb_start), 1);
    for (int i = 0; i < TO - 1; i++) tick();
    chk("to_err_early", int'(err_timeout), 0);
    chk("to_busy_early", int'(busy), 1);
    tick();
    chk("to_err_set", int'(err_timeout), 1);
    chk("to_busy_idle", int'(busy), 0);
    tick(); tick();
    chk("to_no_retry", fb_cnt - fb0, 1);
    chk("to_err_sticky", int'(err_timeout), 1);

    // Next command clears the flag; reset mid-burst in FB_WAIT
    start_cmd(1'b0, 'h80, 0);
    chk("to_err_cleared", int'(err_timeout), 0);
    chk("rst_mid_rx_ready", int'(rx_ready), 1);
    rx_valid = 1'b1; data_rx = 8'h77;
    tick();
    rx_valid = 1'b0;
    n = 0;
    while (!fb_start && n < 50) begin tick(); n++; end
    chk("rst_mid_fl_data", int'(FL_DATA), 'h77);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    fb0 = fb_cnt;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_fb_start", int'(fb_start), 0);
    chk("rst_mid_rx_ready0", int'(rx_ready), 0);
    chk("rst_mid_fl_flow", int'(FL_FLOW), 0);
    chk("rst_mid_fl_addr", int'(FL_ADDR), 0);
    chk("rst_mid_data_tx", int'(data_tx), 0);
    drv = 1'b1; drv_val = 8'h3C;
    tick();
    chk("rst_mid_bus_released", int'(FL_DATA), 'h3C);
    drv = 1'b0;
    fb_done = 1'b1;
    tick();
    fb_done = 1'b0;
    tick(); tick();
    chk("rst_mid_quiet", fb_cnt - fb0, 0);
    for (int i = 0; i < 16; i++) dly[i] = 1;
    run_burst(1'b1, 'h90, 1, 1'b0);

    // Random bursts
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 16; i++) begin
        wq[i]  = 8'($urandom);
        dly[i] = $urandom_range(0, 5);
      end
      run_burst(1'($urandom_range(0, 1)), $urandom_range(0, 255),
                $urandom_range(0, 15), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/manager_flash_burst.md
Name: manager_flash_burst

Overview:
- Parametrised successor to the single-word flash manager FSM.
- Accepts a host command (read/write, start address, word count) on `fl_trg` and runs a burst of flash-bus transactions via the `fb_start`/`fb_done` handshake.
- Read burst: each word is returned to the UART TX path with a `tx_trig`/`tx_done` handshake. Write burst: each word is pulled from the RX path with a `rx_valid`/`rx_ready` handshake.
- Adds address auto-increment with wrap, a flash-bus timeout with error flag, and a properly tri-stated data bus.

Parameters:
- ADDR_W, 8, flash address width
- DATA_W, 8, flash data width
- LEN_W, 4, burst length field width; burst = len_rx+1 words (1..2^LEN_W)
- TIMEOUT_CYC, 1024, max cycles waiting for fb_done before abort (≥2)

Ports:
- CLK_50MHZ  in  1  system clock
- RST  in  1  synchronous active-high reset
- fl_trg  in  1  command strobe, sampled only in IDLE
- cmd_rx  in  1  1=read, 0=write; latched on accepted fl_trg
- addr_rx  in  ADDR_W  start address; latched on accepted fl_trg
- len_rx  in  LEN_W  word count minus one; latched on accepted fl_trg
- data_rx  in  DATA_W  write data word
- rx_valid  in  1  write data valid
- rx_ready  out  1  block ready for write data
- FL_FLOW  out  1  flash direction: 1=read, 0=write
- FL_ADDR  out  ADDR_W  flash address
- FL_DATA  inout  DATA_W  flash data bus
- fb_start  out  1  one-cycle flash transaction start
- fb_done  in  1  flash transaction complete
- data_tx  out  DATA_W  read word to TX path (registered, held)
- tx_trig  out  1  one-cycle TX request
- tx_done  in  1  TX path finished with data_tx
- busy  out  1  high in every state except IDLE
- err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (synchronous, active-high, RST high at an edge):
  - state=IDLE; all outputs 0 (FL_ADDR=0, data_tx=0, err_timeout=0); FL_DATA released (Z); all counters 0.
  - RST mid-burst aborts immediately: no further `fb_start`/`tx_trig`/`rx_ready`.
- All outputs are registered. FL_DATA is driven only when FL_FLOW=0 and state ∈ {FB_START, FB_WAIT}; otherwise Z.
- States: IDLE, WDATA, FB_START, FB_WAIT, TX_TRIG, TX_WAIT.
- IDLE:
  - fl_trg=1 → latch cmd/addr/len into cur_addr, remain=len, and clear err_timeout.
  - Next state: read → FB_START; write → WDATA.
- WDATA:
  - rx_ready=1.
  - On rx_valid&&rx_ready: latch data_rx into wbuf, rx_ready→0 → FB_START.
- FB_START (exactly 1 cycle):
  - fb_start=1; FL_ADDR=cur_addr; FL_FLOW=cmd; FL_DATA=wbuf when writing.
  - Next state: FB_WAIT.
- FB_WAIT:
  - FL_ADDR/FL_FLOW/FL_DATA held; tcnt increments each cycle.
  - On fb_done: tcnt=0. Read → capture FL_DATA into data_tx at the same edge → TX_TRIG. Write → go to NEXT logic.
  - If tcnt reaches TIMEOUT_CYC-1 without fb_done: err_timeout=1 → IDLE (burst aborted).
  - fb_done and timeout on the same cycle: fb_done wins.
- TX_TRIG (1 cycle): tx_trig=1 → TX_WAIT.
- TX_WAIT: on tx_done → NEXT logic. tx_done has no timeout.
- NEXT logic (combinational, applied on the exiting transition):
  - remain==0 → IDLE.
  - Otherwise remain−1 and cur_addr+1, wrapping modulo 2^ADDR_W (0xFF→0x00 at ADDR_W=8). Next state: read → FB_START; write → WDATA.
- Stray inputs are ignored: fb_done outside FB_WAIT, tx_done outside TX_WAIT, rx_valid outside WDATA, fl_trg outside IDLE.
- Latency, read: fl_trg sampled at edge k → fb_start high k+1..k+2. fb_done sampled at edge m → data_tx valid after m, tx_trig high m+1..m+2.
- Inter-word gap, read: tx_done at edge n → next fb_start after n+1.
- Write word accepted at edge w → fb_start high after w+1.
- busy falls on the same edge that enters IDLE.

Test Plan:
- Read, len=0, addr=0x10; fb_done after 3 cycles with FL_DATA=0xA5 → exactly one fb_start with FL_ADDR=0x10, FL_FLOW=1; data_tx=0xA5; one tx_trig; after tx_done, busy=0.
- Read burst, len=3, addr=0xFE → FL_ADDR sequence FE,FF,00,01; four tx_trig pulses with matching data; no tx_trig before each tx_done.
- Write burst, len=1, addr=0x20; rx words 0x11 then 0x22, with rx_valid delayed 5 cycles on word 2 → FL_DATA driven 0x11@0x20, then 0x22@0x21; FL_FLOW=0; bus Z outside FB states; no tx_trig.
- Timeout, TIMEOUT_CYC=8, fb_done never asserted → err_timeout=1 after 8 FB_WAIT cycles; back to IDLE; next fl_trg clears err_timeout.
- Stray stimulus: fl_trg and fb_done pulsed during TX_WAIT → ignored; burst count and addresses unchanged.
- RST asserted in FB_WAIT mid-burst → next cycle all outputs 0, FL_DATA Z, state IDLE; a following fl_trg starts cleanly.
